// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter: grants one completed functional unit per cycle,
// broadcasts its tag/result on a registered CDB and returns the tag to the dispatch tag FIFO.
module cdb_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    localparam int PTR_W    = $clog2(NUM_UNITS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_UNITS-1:0]        unit_valid,
    input  logic [NUM_UNITS*TAG_W-1:0]  unit_tag,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
    output logic [NUM_UNITS-1:0]        unit_ready,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_data,
    output logic                        tag_push,
    output logic [TAG_W-1:0]            tag_in,
    input  logic                        fifo_full,
    output logic [1:0]                  dbg_state,
    output logic [PTR_W-1:0]            dbg_rr_ptr
);

    // Handshake: unit i transfers in a cycle where unit_valid[i] && unit_ready[i];
    // units hold valid and payload stable until granted, and the tag FIFO accepts
    // a push in any cycle where tag_push && !fifo_full.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BCAST = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    cand;
    logic [PTR_W-1:0]    ptr_nxt;
    logic                grant_found;
    logic                grant_ok;
    logic                transfer;
    logic [TAG_W-1:0]    ret_tag;
    logic [DATA_W-1:0]   ret_data;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_UNITS);
            if (!grant_found && unit_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A pending return blocks new grants until the FIFO accepts it.
    assign grant_ok = (state == IDLE) || !fifo_full;
    assign transfer = grant_found && grant_ok && !rst;
    assign ptr_nxt  = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        unit_ready = '0;
        if (transfer) begin
            unit_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (transfer) begin
            state_nxt = BCAST;
        end else if (state != IDLE && fifo_full) begin
            state_nxt = HOLD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            ret_tag  <= '0;
            ret_data <= '0;
        end else if (transfer) begin
            rr_ptr   <= ptr_nxt;
            ret_tag  <= unit_tag[int'(grant_idx)*TAG_W +: TAG_W];
            ret_data <= unit_data[int'(grant_idx)*DATA_W +: DATA_W];
        end
    end

    // The CDB payload and the returned tag share one register set.
    assign cdb_valid  = (state == BCAST);
    assign cdb_tag    = ret_tag;
    assign cdb_data   = ret_data;
    assign tag_push   = (state != IDLE);
    assign tag_in     = ret_tag;
    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a cycle-level reference model predicts grants and
// pushes expected broadcasts into a queue that is popped when the CDB strobes.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int M_IDLE  = 0;
    localparam int M_BCAST = 1;
    localparam int M_HOLD  = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    unit_valid;
    logic [N*TW-1:0] unit_tag;
    logic [N*DW-1:0] unit_data;
    logic [N-1:0]    unit_ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic            tag_push;
    logic [TW-1:0]   tag_in;
    logic            fifo_full;
    logic [1:0]      dbg_state;
    logic [1:0]      dbg_rr_ptr;

    cdb_arbiter #(.NUM_UNITS(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .unit_valid (unit_valid),
        .unit_tag   (unit_tag),
        .unit_data  (unit_data),
        .unit_ready (unit_ready),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .tag_push   (tag_push),
        .tag_in     (tag_in),
        .fifo_full  (fifo_full),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and reference model
    logic [TW+DW-1:0] exp_q[$];
    logic [TW+DW-1:0] exp_item;
    logic [TW-1:0]    mtag [N];
    logic [DW-1:0]    mdata[N];
    int               m_state;
    int               m_rr;
    logic [TW-1:0]    m_ret;
    logic [DW-1:0]    m_cdb_data;
    logic [N-1:0]     last_ready;
    int               checks;
    int               errors;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_unit(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        unit_tag[i*TW +: TW]  = t;
        unit_data[i*DW +: DW] = d;
        mtag[i]  = t;
        mdata[i] = d;
    endtask

    task automatic model_reset();
        m_state    = M_IDLE;
        m_rr       = 0;
        m_ret      = '0;
        m_cdb_data = '0;
        exp_q.delete();
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic cycle(input logic [N-1:0] v, input logic full);
        logic [N-1:0] exp_ready;
        logic         ok;
        int           g;
        unit_valid = v;
        fifo_full  = full;
        #1;
        chk("cdb_valid", cdb_valid, m_state == M_BCAST);
        chk("tag_push", tag_push, m_state != M_IDLE);
        chk("tag_in", tag_in, m_ret);
        chk("cdb_tag_hold", cdb_tag, m_ret);
        chk("cdb_data_hold", cdb_data, m_cdb_data);
        chk("rr_ptr", dbg_rr_ptr, m_rr);
        chk("state", dbg_state, m_state);
        if (cdb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_bcast", 1, 0);
            end else begin
                exp_item = exp_q.pop_front();
                chk("sb_bcast", {cdb_tag, cdb_data}, exp_item);
            end
        end
        ok = (m_state == M_IDLE) || !full;
        g  = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (g < 0 && v[idx]) g = idx;
        end
        exp_ready = '0;
        if (ok && g >= 0) exp_ready[g] = 1'b1;
        chk("unit_ready", unit_ready, exp_ready);
        last_ready = unit_ready;
        if (ok && g >= 0) begin
            exp_q.push_back({mtag[g], mdata[g]});
            m_ret      = mtag[g];
            m_cdb_data = mdata[g];
            m_rr       = (g + 1) % N;
            m_state    = M_BCAST;
        end else if (m_state != M_IDLE && full) begin
            m_state = M_HOLD;
        end else begin
            m_state = M_IDLE;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        fifo_full = 1'b0;
        unit_valid = '1;
        unit_tag  = '0;
        unit_data = '0;
        set_unit(0, 6'h01, 32'h0000_0100);
        set_unit(1, 6'h0A, 32'hDEAD_BEEF);
        set_unit(2, 6'h22, 32'h2222_0002);
        set_unit(3, 6'h33, 32'h3333_0003);
        model_reset();

        // reset values, with every unit requesting
        #3;
        chk("rst_unit_ready", unit_ready, 4'b0000);
        chk("rst_cdb_valid", cdb_valid, 1'b0);
        chk("rst_cdb_tag", cdb_tag, 6'h00);
        chk("rst_cdb_data", cdb_data, 32'h0);
        chk("rst_tag_push", tag_push, 1'b0);
        chk("rst_tag_in", tag_in, 6'h00);
        chk("rst_rr_ptr", dbg_rr_ptr, 2'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        unit_valid = '0;

        // single unit, granted in cycle 3, broadcast in cycle 4
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0010, 1'b0);
        chk("single_ready", last_ready, 4'b0010);
        chk("single_cdb_valid", cdb_valid, 1'b1);
        chk("single_cdb_tag", cdb_tag, 6'h0A);
        chk("single_cdb_data", cdb_data, 32'hDEAD_BEEF);
        chk("single_tag_push", tag_push, 1'b1);
        chk("single_tag_in", tag_in, 6'h0A);
        cycle(4'b0000, 1'b0);

        // bring rr_ptr to 0, then all units valid for five cycles
        cycle(4'b1000, 1'b0);
        chk("rr_start", dbg_rr_ptr, 2'd0);
        for (int k = 0; k < 5; k++) begin
            cycle(4'b1111, 1'b0);
            chk("rr_grant", last_ready, 4'b0001 << (k % 4));
        end
        cycle(4'b0000, 1'b0);

        // full FIFO for three cycles after broadcast of tag 0x07
        set_unit(1, 6'h07, 32'h0700_0007);
        set_unit(3, 6'h1C, 32'h1C1C_1C1C);
        cycle(4'b0010, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("full_tag_push", tag_push, 1'b1);
            chk("full_tag_in", tag_in, 6'h07);
            cycle(4'b1000, (k < 3) ? 1'b1 : 1'b0);
            chk("full_ready", last_ready, (k < 3) ? 4'b0000 : 4'b1000);
        end
        cycle(4'b0000, 1'b0);

        // wrap and skip from rr_ptr=3 with units 0 and 2 requesting
        set_unit(2, 6'h2A, 32'h2A2A_0000);
        cycle(4'b0100, 1'b0);
        chk("wrap_start", dbg_rr_ptr, 2'd3);
        cycle(4'b0101, 1'b0);
        chk("wrap_first", last_ready, 4'b0001);
        chk("wrap_rr1", dbg_rr_ptr, 2'd1);
        cycle(4'b0100, 1'b0);
        chk("wrap_second", last_ready, 4'b0100);
        chk("wrap_rr3", dbg_rr_ptr, 2'd3);
        cycle(4'b0000, 1'b0);

        // idle for ten cycles
        for (int k = 0; k < 10; k++) begin
            cycle(4'b0000, 1'b0);
            chk("idle_cdb_tag", cdb_tag, 6'h2A);
        end

        // reset while holding tag 0x15
        set_unit(0, 6'h15, 32'h1515_1515);
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b1);
        chk("hold_state", dbg_state, 2'd2);
        chk("hold_tag_in", tag_in, 6'h15);
        unit_valid = 4'b0100;
        rst = 1'b1;
        #1;
        chk("midrst_tag_push", tag_push, 1'b0);
        chk("midrst_cdb_valid", cdb_valid, 1'b0);
        chk("midrst_rr_ptr", dbg_rr_ptr, 2'd0);
        chk("midrst_unit_ready", unit_ready, 4'b0000);
        chk("midrst_tag_in", tag_in, 6'h00);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(4'b0100, 1'b0);
        chk("postrst_grant", last_ready, 4'b0100);
        cycle(4'b0000, 1'b0);

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Return end of the tag free-list protocol in the Tomasulo core. Functional units complete and request the Common Data Bus. This block grants one unit per cycle with a round-robin policy, broadcasts the winner's tag and result on a registered CDB, and pushes the retired tag back into the dispatch tag FIFO. If the FIFO reports full, the block holds the return and stops granting until the push is accepted.

## Interface
- NUM_UNITS, 4, number of functional-unit requesters (2..8)
- TAG_W, 6, tag width; matches the tag FIFO
- DATA_W, 32, result width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- unit_valid  in  NUM_UNITS  unit i has a completed result
- unit_tag  in  NUM_UNITS*TAG_W  unit i tag, packed in slice [i*TAG_W +: TAG_W]
- unit_data  in  NUM_UNITS*DATA_W  unit i result, packed in slice [i*DATA_W +: DATA_W]
- unit_ready  out  NUM_UNITS  one-hot grant; a transfer happens when unit_valid[i] and unit_ready[i] are both high
- cdb_valid  out  1  broadcast strobe, one cycle per result
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast result
- tag_push  out  1  push request to the tag FIFO
- tag_in  out  TAG_W  tag returned to the FIFO
- fifo_full  in  1  tag FIFO full indicator; a push is accepted only when this is low

## Operation
- State machine with states IDLE, BCAST and HOLD.
  - IDLE: no return is pending.
  - BCAST: cdb_valid=1 this cycle, and the return is being pushed.
  - HOLD: the return is pending and not yet accepted.
- grant_ok = (state==IDLE) or (state==BCAST and !fifo_full) or (state==HOLD and !fifo_full).
- Arbitration is combinational.
  - Search unit_valid starting at rr_ptr, wrapping modulo NUM_UNITS.
  - The first valid unit g gets unit_ready[g]=1, but only when grant_ok.
  - unit_ready is all zero when no unit is valid or when grant_ok=0.
  - unit_ready never depends on a unit's own data.
- On a transfer:
  - Register g's tag and data into cdb_tag/cdb_data and into ret_tag.
  - rr_ptr <= (g+1) mod NUM_UNITS.
  - Next state is BCAST.
- Without a transfer:
  - From BCAST or HOLD with fifo_full=1, go to HOLD.
  - Otherwise go to IDLE.
  - rr_ptr is unchanged.
- cdb_valid=1 only in BCAST; cdb_tag/cdb_data hold their last value otherwise.
- tag_push=1 in BCAST and HOLD; tag_in=ret_tag.
- The block does not check whether the tag FIFO drops or duplicates tags. Tag uniqueness is owned by dispatch.
- A unit's request is not accepted when it is not granted. Units keep unit_valid and the payload stable until granted.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0
  - cdb_valid=0, cdb_tag=0, cdb_data=0
  - tag_push=0, tag_in=0
  - unit_ready=0 while rst is high
- Latency: a transfer in cycle N gives cdb_valid and tag_push high in cycle N+1.
- Throughput: one broadcast per cycle, sustained while fifo_full=0.
- Backpressure: with fifo_full=1 in cycle N+1, tag_push stays high and tag_in stays stable until the first cycle in which fifo_full=0. That cycle is the accept cycle, and it may carry a new grant.
- cdb_valid never repeats for the same transfer while the block is in HOLD.
- With a single requester, that unit is granted every cycle it is valid; rr_ptr wraps past it back to the same unit.
- Simultaneous requests in one cycle: exactly one grant. The others are served in round-robin order in later cycles.
- Reset mid-operation discards the pending return and any registered broadcast. Outputs return to their reset values asynchronously.

## Test plan
- **Reset:** assert rst during HOLD with tag 0x15 pending -> tag_push=0, cdb_valid=0 and rr_ptr=0 immediately; after release, a lone unit 2 request is granted.
- **Single unit:** unit 1 valid with tag 0x0A, data 0xDEADBEEF in cycle 3 -> unit_ready=4'b0010 in cycle 3; cdb_valid=1, cdb_tag=0x0A, cdb_data=0xDEADBEEF, tag_push=1, tag_in=0x0A in cycle 4.
- **Round-robin fairness:** all 4 units valid continuously, rr_ptr=0 -> grants 0,1,2,3,0 over five consecutive cycles; one cdb_valid per cycle with matching tags.
- **Full FIFO:** fifo_full=1 for 3 cycles after the broadcast of tag 0x07 -> tag_push held high with tag_in=0x07 for 4 cycles; unit_ready=0 for 3 cycles; a new grant in the accept cycle.
- **Wrap and skip:** rr_ptr=3 with units 0 and 2 valid -> unit 0 granted first, then unit 2; rr_ptr becomes 1, then 3.
- **Idle:** no unit_valid for 10 cycles -> cdb_valid=0 and tag_push=0 throughout; cdb_tag keeps its last value.
